mac_accumulator: RTL and testbench

Downstream consumer of the 3-stage multiply-add pipeline (`result = a*b + c`). It tracks which pipeline slots carry real operands, sums `VEC_LEN` consecutive valid results into one wide dot-product total, and presents each total through a valid/ready output register. It sits between the multiply-add pipeline and the result bus.

---
 rtl/mac_accumulator.sv | 160 ++++++++++++++++
 tb/tb_mac_accumulator.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mac_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : mac_accumulator
//  Description : Sums VEC_LEN consecutive valid results from the 3-stage
//                multiply-add pipeline into one wide dot-product total and
//                presents each total through a valid/ready output register.
//                Optional clamping of the total is enabled with the macro
//                MAC_ACC_SAT_EN (default build: sum wraps, sat tied to 0).
//  Revision    : 1.0 - initial release
// ============================================================================
module mac_accumulator #(
    parameter int VEC_LEN = 4,
    parameter int LAT     = 3,
    parameter int ACC_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [7:0]       in_result,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [ACC_W-1:0] out_sum,
    output logic             busy,
    output logic             overrun,
    output logic             sat
);

    // Count only needs to reach VEC_LEN-1; completion resets it to 0.
    localparam int c_cnt_w = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(VEC_LEN - 1);

    typedef enum logic [0:0] {
        ACC_IDLE = 1'b0,
        ACC_RUN  = 1'b1
    } acc_state_t;

    acc_state_t         r_state;
    logic [c_cnt_w-1:0] r_count;
    logic [ACC_W-1:0]   r_acc;
    logic [LAT-1:0]     r_vld_sr;
    logic               r_busy;
    logic               r_out_valid;
    logic [ACC_W-1:0]   r_out_sum;
    logic               r_overrun;

    logic               w_smp;
    logic               w_done;
    logic               w_out_load;
    logic [ACC_W-1:0]   w_base;
    logic [ACC_W-1:0]   w_acc_next;

    // Valid tracking mirrors the upstream pipeline so in_result can be
    // qualified without any handshake from the fixed-latency datapath.
    generate
        if (LAT == 1) begin : g_sr_single
            // Single-stage valid tracker
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_vld_sr <= '0;
                end else begin
                    r_vld_sr <= in_valid;
                end
            end
        end else begin : g_sr_multi
            // Multi-stage valid tracker shifting toward the sample point
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_vld_sr <= '0;
                end else begin
                    r_vld_sr <= {r_vld_sr[LAT-2:0], in_valid};
                end
            end
        end
    endgenerate

    assign w_smp      = r_vld_sr[LAT-1];
    assign w_done     = w_smp && (r_count == c_cnt_last);
    assign w_out_load = w_done && (!r_out_valid || out_ready);

    // First sample of a vector loads directly: no clear cycle is needed.
    assign w_base = (r_state == ACC_IDLE) ? '0 : r_acc;

`ifdef MAC_ACC_SAT_EN
    logic [ACC_W:0] w_sum_wide;
    logic           w_flag_next;
    logic           r_flag;
    logic           r_sat;

    assign w_sum_wide  = {1'b0, w_base} + (ACC_W + 1)'(in_result);
    assign w_acc_next  = w_sum_wide[ACC_W] ? {ACC_W{1'b1}} : w_sum_wide[ACC_W-1:0];
    // Flag is ignored in ACC_IDLE so each new vector starts unclamped.
    assign w_flag_next = ((r_state == ACC_RUN) && r_flag) || w_sum_wide[ACC_W];

    // Sticky-per-vector clamp flag and its copy alongside out_sum
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flag <= 1'b0;
            r_sat  <= 1'b0;
        end else begin
            if (w_smp) begin
                r_flag <= w_flag_next;
            end
            if (w_out_load) begin
                r_sat <= w_flag_next;
            end
        end
    end

    assign sat = r_sat;
`else
    assign w_acc_next = w_base + ACC_W'(in_result);
    assign sat        = 1'b0;
`endif

    // Accumulation state machine: count samples, close a total on the last
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ACC_IDLE;
            r_count <= '0;
            r_acc   <= '0;
            r_busy  <= 1'b0;
        end else if (w_smp) begin
            r_acc <= w_acc_next;
            if (w_done) begin
                r_state <= ACC_IDLE;
                r_count <= '0;
                r_busy  <= 1'b0;
            end else begin
                r_state <= ACC_RUN;
                r_count <= r_count + c_cnt_w'(1);
                r_busy  <= 1'b1;
            end
        end
    end

    // Output register: load when free or being drained, else drop and flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_out_load) begin
                r_out_valid <= 1'b1;
                r_out_sum   <= w_acc_next;
            end else if (w_done) begin
                r_overrun   <= 1'b1;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign busy      = r_busy;
    assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_mac_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mac_accumulator
//  Description : Directed self-checking bench for mac_accumulator. Three
//                instances cover the default build, a narrow 2-sample
//                accumulator (wrap / MAC_ACC_SAT_EN clamp) and VEC_LEN = 1.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_accumulator;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Instance A: defaults (VEC_LEN=4, LAT=3, ACC_W=16)
    logic        a_valid = 1'b0;
    logic [7:0]  a_a = '0, a_b = '0, a_c = '0;
    logic [7:0]  a_p0 = '0, a_p1 = '0, a_p2 = '0;
    logic        a_ready = 1'b1;
    logic        a_ov, a_busy, a_ovr, a_sat;
    logic [15:0] a_sum;

    // Instance B: VEC_LEN=2, ACC_W=8
    logic        b_valid = 1'b0;
    logic [7:0]  b_val = '0;
    logic [7:0]  b_p0 = '0, b_p1 = '0, b_p2 = '0;
    logic        b_ready = 1'b1;
    logic        b_ov, b_busy, b_ovr, b_sat;
    logic [7:0]  b_sum;

    // Instance C: VEC_LEN=1
    logic        c_valid = 1'b0;
    logic [7:0]  c_val = '0;
    logic [7:0]  c_p0 = '0, c_p1 = '0, c_p2 = '0;
    logic        c_ready = 1'b1;
    logic        c_ov, c_busy, c_ovr, c_sat;
    logic [15:0] c_sum;

    // Behavioural 3-stage multiply-add pipelines feeding each instance
    always @(posedge clk) begin
        a_p0 <= a_a * a_b + a_c;
        a_p1 <= a_p0;
        a_p2 <= a_p1;
        b_p0 <= b_val;
        b_p1 <= b_p0;
        b_p2 <= b_p1;
        c_p0 <= c_val;
        c_p1 <= c_p0;
        c_p2 <= c_p1;
    end

    mac_accumulator u_a (
        .clk(clk), .rst(rst), .in_valid(a_valid), .in_result(a_p2),
        .out_ready(a_ready), .out_valid(a_ov), .out_sum(a_sum),
        .busy(a_busy), .overrun(a_ovr), .sat(a_sat)
    );

    mac_accumulator #(.VEC_LEN(2), .LAT(3), .ACC_W(8)) u_b (
        .clk(clk), .rst(rst), .in_valid(b_valid), .in_result(b_p2),
        .out_ready(b_ready), .out_valid(b_ov), .out_sum(b_sum),
        .busy(b_busy), .overrun(b_ovr), .sat(b_sat)
    );

    mac_accumulator #(.VEC_LEN(1), .LAT(3), .ACC_W(16)) u_c (
        .clk(clk), .rst(rst), .in_valid(c_valid), .in_result(c_p2),
        .out_ready(c_ready), .out_valid(c_ov), .out_sum(c_sum),
        .busy(c_busy), .overrun(c_ovr), .sat(c_sat)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send_a(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        a_valid = 1'b1; a_a = a; a_b = b; a_c = c;
        @(negedge clk);
    endtask

    task automatic bub_a();
        a_valid = 1'b0; a_a = 8'd15; a_b = 8'd15; a_c = 8'd0;
        @(negedge clk);
    endtask

    task automatic send_b(input logic [7:0] v);
        b_valid = 1'b1; b_val = v;
        @(negedge clk);
    endtask

    task automatic send_c(input logic [7:0] v);
        c_valid = 1'b1; c_val = v;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        a_valid = 1'b0; a_a = '0; a_b = '0; a_c = '0;
        b_valid = 1'b0; b_val = '0;
        c_valid = 1'b0; c_val = '0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(a_ov), 0);
        chk("rst_out_sum",   32'(a_sum), 0);
        chk("rst_busy",      32'(a_busy), 0);
        chk("rst_overrun",   32'(a_ovr), 0);
        chk("rst_sat",       32'(a_sat), 0);
        rst = 1'b0;

        // Basic sum: 1*2+2*2+3*2+4*2 = 20, valid 3 edges after last in_valid
        send_a(1, 2, 0); send_a(2, 2, 0); send_a(3, 2, 0); send_a(4, 2, 0);
        chk("basic_busy_first", 32'(a_busy), 1);
        idle(2);
        chk("basic_not_early",  32'(a_ov), 0);
        chk("basic_busy_mid",   32'(a_busy), 1);
        idle(1);
        chk("basic_valid",      32'(a_ov), 1);
        chk("basic_sum",        32'(a_sum), 20);
        chk("basic_busy_done",  32'(a_busy), 0);
        idle(1);
        chk("basic_one_cycle",  32'(a_ov), 0);

        // Gapped input with 15*15 bubbles that must be ignored
        send_a(1, 2, 0); bub_a(); send_a(2, 2, 0); bub_a();
        send_a(3, 2, 0); bub_a(); send_a(4, 2, 0);
        idle(2);
        chk("gap_not_early", 32'(a_ov), 0);
        idle(1);
        chk("gap_valid",     32'(a_ov), 1);
        chk("gap_sum",       32'(a_sum), 20);
        idle(1);
        chk("gap_drained",   32'(a_ov), 0);

        // Backpressure: first total 8 held, second (12) dropped
        a_ready = 1'b0;
        repeat (4) send_a(1, 1, 1);
        repeat (3) send_a(1, 1, 2);
        chk("bp_first_valid",   32'(a_ov), 1);
        chk("bp_first_sum",     32'(a_sum), 8);
        chk("bp_no_overrun",    32'(a_ovr), 0);
        send_a(1, 1, 2);
        idle(3);
        chk("bp_held_valid",    32'(a_ov), 1);
        chk("bp_held_sum",      32'(a_sum), 8);
        chk("bp_overrun",       32'(a_ovr), 1);
        a_ready = 1'b1;
        idle(1);
        chk("bp_drained",       32'(a_ov), 0);
        chk("bp_overrun_stuck", 32'(a_ovr), 1);

        rst = 1'b1;
        idle(1);
        chk("rst2_overrun", 32'(a_ovr), 0);
        chk("rst2_sum",     32'(a_sum), 0);
        rst = 1'b0;

        // Same, but out_ready high exactly on the second completion edge
        a_ready = 1'b0;
        repeat (4) send_a(1, 1, 1);
        repeat (4) send_a(1, 1, 2);
        idle(2);
        a_ready = 1'b1;
        idle(1);
        a_ready = 1'b0;
        chk("rdy_valid",      32'(a_ov), 1);
        chk("rdy_second_sum", 32'(a_sum), 12);
        chk("rdy_no_overrun", 32'(a_ovr), 0);
        a_ready = 1'b1;
        idle(1);
        chk("rdy_drained",    32'(a_ov), 0);

        // Reset mid-vector with stale results still in the pipeline
        repeat (4) send_a(1, 2, 0);
        idle(1);
        chk("mid_busy", 32'(a_busy), 1);
        rst = 1'b1;
        idle(1);
        chk("mid_rst_valid",   32'(a_ov), 0);
        chk("mid_rst_sum",     32'(a_sum), 0);
        chk("mid_rst_busy",    32'(a_busy), 0);
        chk("mid_rst_overrun", 32'(a_ovr), 0);
        chk("mid_rst_sat",     32'(a_sat), 0);
        rst = 1'b0;
        repeat (4) send_a(5, 1, 0);
        idle(3);
        chk("fresh_valid", 32'(a_ov), 1);
        chk("fresh_sum",   32'(a_sum), 20);
        idle(1);

        // Narrow accumulator: 200 + 100 overflows 8 bits
        send_b(200); send_b(100);
        idle(2);
        chk("ovf_not_early", 32'(b_ov), 0);
        idle(1);
        chk("ovf_valid",     32'(b_ov), 1);
`ifdef MAC_ACC_SAT_EN
        chk("ovf_sum",       32'(b_sum), 255);
        chk("ovf_sat",       32'(b_sat), 1);
`else
        chk("ovf_sum",       32'(b_sum), 44);
        chk("ovf_sat",       32'(b_sat), 0);
`endif
        idle(1);
        chk("ovf_drained",   32'(b_ov), 0);

        // VEC_LEN = 1: every sample is its own total
        send_c(7); send_c(9);
        idle(1);
        chk("v1_not_early", 32'(c_ov), 0);
        idle(1);
        chk("v1_valid0",    32'(c_ov), 1);
        chk("v1_sum0",      32'(c_sum), 7);
        chk("v1_busy0",     32'(c_busy), 0);
        idle(1);
        chk("v1_valid1",    32'(c_ov), 1);
        chk("v1_sum1",      32'(c_sum), 9);
        chk("v1_busy1",     32'(c_busy), 0);
        idle(1);
        chk("v1_drained",   32'(c_ov), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
